// File: rtl/led_matrix_column_scanner.sv
// Column scanner for the 5x7 LED matrix with a double-buffered frame.
// Frames swap only at the column-4 wrap so a scan never tears.
module led_matrix_column_scanner #(
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [34:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [34:0] active_frame,
  output logic [2:0]  bin_number,
  output logic [4:0]  cols,
  output logic        blank,
  output logic        frame_done
);

  localparam int SW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SW-1:0] BLANK_LAST =
    SW'(BLANK_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST =
    SW'(CLK_DIV - 1);
  localparam logic [4:0] COLS_OFF =
    COL_ACTIVE_LOW ? 5'b11111 : 5'b00000;

  typedef enum logic {
    s_blank,
    s_drive
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] slot_cnt;
  logic [SW-1:0] slot_n;
  logic [2:0]    col;
  logic [2:0]    col_n;
  logic [34:0]   pending;
  logic          pend_full;
  logic          pend_full_n;
  logic          slot_end;
  logic          wrap;
  logic          accept;
  logic [4:0]    on;
  logic [4:0]    cols_d;
  logic          blank_d;

  assign slot_end = (state == s_drive) &&
                    (slot_cnt == SLOT_LAST);
  assign wrap     = slot_end && (col == 3'd4);
  assign accept   = frame_valid && frame_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= s_blank;
      slot_cnt <= '0;
      col      <= '0;
    end else begin
      state    <= state_n;
      slot_cnt <= slot_n;
      col      <= col_n;
    end
  end

  always_comb begin
    state_n = state;
    slot_n  = slot_cnt + 1'b1;
    col_n   = col;
    unique case (1'b1)
      (state == s_blank): begin
        if (slot_cnt == BLANK_LAST)
          state_n = s_drive;
      end
      (state == s_drive): begin
        if (slot_end) begin
          state_n = s_blank;
          slot_n  = '0;
          col_n   = (col == 3'd4) ? 3'd0
                                  : col + 3'd1;
        end
      end
      default: state_n = s_blank;
    endcase
  end

  // Outputs are computed from next state so they land registered.
  always_comb begin
    on      = 5'b00001 << col_n;
    cols_d  = COLS_OFF;
    blank_d = 1'b1;
    if (state_n == s_drive) begin
      cols_d  = COL_ACTIVE_LOW ? ~on : on;
      blank_d = 1'b0;
    end
    pend_full_n = pend_full;
    if (wrap && pend_full)
      pend_full_n = 1'b0;
    if (accept)
      pend_full_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cols         <= COLS_OFF;
      blank        <= 1'b1;
      bin_number   <= '0;
      frame_done   <= 1'b0;
      active_frame <= '0;
      pending      <= '0;
      pend_full    <= 1'b0;
      frame_ready  <= 1'b1;
    end else begin
      cols       <= cols_d;
      blank      <= blank_d;
      bin_number <= col_n;
      frame_done <= wrap;
      if (wrap && pend_full)
        active_frame <= pending;
      if (accept)
        pending <= frame_in;
      pend_full   <= pend_full_n;
      frame_ready <= !pend_full_n;
    end
  end

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Scoreboard bench for led_matrix_column_scanner.
// CLK_DIV=8, BLANK_CYCLES=2, active-low columns.
module tb_led_matrix_column_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [34:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [34:0] active_frame;
  logic [2:0]  bin_number;
  logic [4:0]  cols;
  logic        blank;
  logic        frame_done;

  led_matrix_column_scanner #(
    .CLK_DIV(8),
    .BLANK_CYCLES(2),
    .COL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_in(frame_in),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .active_frame(active_frame),
    .bin_number(bin_number),
    .cols(cols),
    .blank(blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sig;
    logic [34:0] val;
  } exp_t;

  exp_t        expq[$];
  logic [34:0] frameq[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk)
    cyc <= reset ? 0 : cyc + 1;

  task automatic chk(string nm, logic [34:0] act,
                     logic [34:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, req);
    end
  endtask

  task automatic push(int c, int s, logic [34:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    expq.push_back(e);
  endtask

  task automatic wait_until(int c);
    int guard = 0;
    while (cyc != c) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL timeout waiting cyc=%0d", c);
        $fatal(1, "timeout");
      end
    end
  endtask

  // Independent timing model derived from the cycle number.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      int slot;
      int c;
      logic [4:0] ec;
      slot = cyc % 8;
      c = (cyc / 8) % 5;
      ec = (slot >= 2) ? ~(5'b00001 << c) : 5'b11111;
      chk("cols", {30'd0, cols}, {30'd0, ec});
      chk("blank", {34'd0, blank},
          {34'd0, (slot < 2)});
      chk("bin", {32'd0, bin_number}, 35'(c));
      chk("done", {34'd0, frame_done},
          {34'd0, (cyc > 0 && cyc % 40 == 0)});
      if (frame_done) begin
        if (frameq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL frame_unexp cyc=%0d got=%h want=none",
                   cyc, active_frame);
        end else begin
          chk("frame_swap", active_frame,
              frameq.pop_front());
        end
      end
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
        exp_t e;
        e = expq.pop_front();
        if (e.cyc < cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL stale cyc=%0d got=%0d want=%0d",
                   cyc, cyc, e.cyc);
        end else if (e.sig == 0) begin
          chk("ready", {34'd0, frame_ready}, e.val);
        end else begin
          chk("active", active_frame, e.val);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    push(0, 0, 35'd1);
    push(0, 1, 35'd0);
    push(5, 0, 35'd1);
    push(6, 0, 35'd0);
    push(20, 0, 35'd0);
    push(39, 1, 35'd0);
    push(39, 0, 35'd0);
    push(40, 1, 35'h7_FFFF_FFFF);
    push(40, 0, 35'd1);
    push(45, 0, 35'd1);
    push(79, 0, 35'd1);
    push(80, 1, 35'h7_FFFF_FFFF);
    push(80, 0, 35'd0);
    push(119, 1, 35'h7_FFFF_FFFF);
    push(120, 1, 35'h1_2345_6789);
    push(120, 0, 35'd1);
    push(126, 0, 35'd0);
    push(145, 1, 35'h1_2345_6789);
    frameq.push_back(35'h7_FFFF_FFFF);
    frameq.push_back(35'h7_FFFF_FFFF);
    frameq.push_back(35'h1_2345_6789);

    wait_until(5);
    frame_in    = 35'h7_FFFF_FFFF;
    frame_valid = 1'b1;
    wait_until(6);
    frame_valid = 1'b0;
    wait_until(10);
    frame_in    = 35'h0_0000_0001;
    frame_valid = 1'b1;
    wait_until(20);
    frame_valid = 1'b0;
    wait_until(79);
    frame_in    = 35'h1_2345_6789;
    frame_valid = 1'b1;
    wait_until(80);
    frame_valid = 1'b0;
    wait_until(125);
    frame_in    = 35'h5_5555_5555;
    frame_valid = 1'b1;
    wait_until(126);
    frame_valid = 1'b0;

    wait_until(146);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("drain_exp", 35'(expq.size()), 35'd0);
    chk("drain_frm", 35'(frameq.size()), 35'd0);
    push(0, 1, 35'd0);
    push(0, 0, 35'd1);
    push(39, 1, 35'd0);
    push(40, 1, 35'd0);
    push(40, 0, 35'd1);
    frameq.push_back(35'd0);
    wait_until(45);
    chk("end_exp", 35'(expq.size()), 35'd0);
    chk("end_frm", 35'(frameq.size()), 35'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
